// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with data-cache access control.
// Holds one instruction, stalls upstream while a load/store waits for dhit.
module exmem_stage #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_wdat,
    input  logic [4:0]  ex_wsel,
    input  logic [31:0] ex_npc,
    input  logic        ex_regWrite,
    input  logic        ex_memtoReg,
    input  logic        ex_dren,
    input  logic        ex_dwen,
    input  logic        ex_jal,
    input  logic        ex_halt,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        out_valid,
    output logic [31:0] out_aluout,
    output logic [31:0] out_npc,
    output logic [31:0] out_ldata,
    output logic [4:0]  out_wsel,
    output logic        out_regWrite,
    output logic        out_memtoReg,
    output logic        out_jal,
    output logic        out_halt,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_valid;
    logic [31:0] r_aluout;
    logic [31:0] r_wdat;
    logic [4:0]  r_wsel;
    logic [31:0] r_npc;
    logic        r_regWrite;
    logic        r_memtoReg;
    logic        r_dren;
    logic        r_dwen;
    logic        r_jal;
    logic        r_halt;
    logic        r_err_misalign;
    logic        r_err_timeout;
    logic [7:0]  r_wait_cnt;

    logic        w_in_access;
    logic        w_advance;
    logic        w_capture;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_waiting;
    logic [7:0]  w_cnt_inc;

    assign w_in_access = (r_state == S_ACCESS);
    assign w_capture   = ex_valid && !flush;
    assign w_mem_op    = ex_dren || ex_dwen;
    assign w_misalign  = w_mem_op && (ex_aluout[1:0] != 2'b00);
    assign w_waiting   = w_in_access && !dhit;
    assign w_cnt_inc   = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

    // Cache request and handshake; a read wins if both enables were latched.
    assign dmemREN   = w_in_access && r_dren;
    assign dmemWEN   = w_in_access && r_dwen && !r_dren;
    assign dmemaddr  = r_aluout;
    assign dmemstore = r_wdat;
    assign mem_stall = w_waiting;
    assign w_advance = !mem_stall && (r_state != S_HALTED);

    assign out_valid    = r_valid && (!w_in_access || dhit);
    assign out_ldata    = (w_in_access && dhit && r_dren) ? dmemload : 32'h0;
    assign out_aluout   = r_aluout;
    assign out_npc      = r_npc;
    assign out_wsel     = r_wsel;
    assign out_regWrite = r_regWrite;
    assign out_memtoReg = r_memtoReg;
    assign out_jal      = r_jal;
    assign out_halt     = r_halt;
    assign err_misalign = r_err_misalign;
    assign err_timeout  = r_err_timeout;

    always_comb begin
        w_next_state = r_state;
        if (w_advance) begin
            if (w_capture && ex_halt) begin
                w_next_state = S_HALTED;
            end else if (w_capture && w_mem_op && !w_misalign) begin
                w_next_state = S_ACCESS;
            end else begin
                w_next_state = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_valid        <= 1'b0;
            r_aluout       <= 32'h0;
            r_wdat         <= 32'h0;
            r_wsel         <= 5'h0;
            r_npc          <= RESET_PC;
            r_regWrite     <= 1'b0;
            r_memtoReg     <= 1'b0;
            r_dren         <= 1'b0;
            r_dwen         <= 1'b0;
            r_jal          <= 1'b0;
            r_halt         <= 1'b0;
            r_err_misalign <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_wait_cnt     <= 8'h0;
        end else begin
            r_state <= w_next_state;
            if (w_advance) begin
                // A misaligned access retires as a plain non-writing instruction.
                r_valid    <= w_capture;
                r_aluout   <= ex_aluout;
                r_wdat     <= ex_wdat;
                r_wsel     <= ex_wsel;
                r_npc      <= ex_npc;
                r_regWrite <= w_capture && ex_regWrite && !w_misalign;
                r_memtoReg <= w_capture && ex_memtoReg;
                r_dren     <= w_capture && ex_dren && !w_misalign;
                r_dwen     <= w_capture && ex_dwen && !w_misalign;
                r_jal      <= w_capture && ex_jal;
                r_halt     <= w_capture && ex_halt;
                r_wait_cnt <= 8'h0;
                if (w_capture && w_misalign) begin
                    r_err_misalign <= 1'b1;
                end
            end else if (r_state == S_HALTED) begin
                r_valid <= 1'b0;
            end else if (w_waiting) begin
                r_wait_cnt <= w_cnt_inc;
                if (32'(w_cnt_inc) >= TIMEOUT) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios plus a randomized
// instruction stream scored against an in-order completion queue.
module tb_exmem_stage;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        CLK;
    logic        RST;
    logic        ex_valid;
    logic [31:0] ex_aluout;
    logic [31:0] ex_wdat;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_npc;
    logic        ex_regWrite, ex_memtoReg, ex_dren, ex_dwen, ex_jal, ex_halt;
    logic        flush;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_stall, out_valid;
    logic [31:0] out_aluout, out_npc, out_ldata;
    logic [4:0]  out_wsel;
    logic        out_regWrite, out_memtoReg, out_jal, out_halt;
    logic        err_misalign, err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    exmem_stage #(.TIMEOUT(255), .RESET_PC(RPC)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_wdat(ex_wdat),
        .ex_wsel(ex_wsel), .ex_npc(ex_npc),
        .ex_regWrite(ex_regWrite), .ex_memtoReg(ex_memtoReg),
        .ex_dren(ex_dren), .ex_dwen(ex_dwen), .ex_jal(ex_jal), .ex_halt(ex_halt),
        .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .out_valid(out_valid),
        .out_aluout(out_aluout), .out_npc(out_npc), .out_ldata(out_ldata),
        .out_wsel(out_wsel), .out_regWrite(out_regWrite),
        .out_memtoReg(out_memtoReg), .out_jal(out_jal), .out_halt(out_halt),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] alu;
        logic [31:0] npc;
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        rw;
        logic        m2r;
        logic        jal;
        logic        ld;
        logic        st;
    } exp_t;

    task automatic clr_in();
        ex_valid = 0; ex_aluout = 0; ex_wdat = 0; ex_wsel = 0; ex_npc = 0;
        ex_regWrite = 0; ex_memtoReg = 0; ex_dren = 0; ex_dwen = 0;
        ex_jal = 0; ex_halt = 0; flush = 0;
    endtask

    // Leaves the caller at a falling edge with reset released.
    task automatic do_reset();
        RST = 1; clr_in(); dhit = 0; dmemload = 0;
        repeat (2) @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_npc !== RPC) begin n_err++; $display("FAIL rst_npc: got %h want %h", out_npc, RPC); end
        n_cmp++; if (out_aluout !== 32'h0) begin n_err++; $display("FAIL rst_aluout: got %h want 0", out_aluout); end
        n_cmp++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin n_err++; $display("FAIL rst_req: got %b want 000", {dmemREN, dmemWEN, mem_stall}); end
        n_cmp++; if ({out_halt, err_misalign, err_timeout} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {out_halt, err_misalign, err_timeout}); end
    endtask

    task automatic test_alu();
        do_reset();
        ex_valid = 1; ex_aluout = 32'h10; ex_wsel = 5; ex_regWrite = 1; ex_npc = 32'h44; ex_jal = 1;
        @(negedge CLK); clr_in(); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL alu_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_aluout !== 32'h10) begin n_err++; $display("FAIL alu_aluout: got %h want 10", out_aluout); end
        n_cmp++; if (out_wsel !== 5'd5) begin n_err++; $display("FAIL alu_wsel: got %0d want 5", out_wsel); end
        n_cmp++; if ({out_regWrite, out_jal} !== 2'b11) begin n_err++; $display("FAIL alu_ctrl: got %b want 11", {out_regWrite, out_jal}); end
        n_cmp++; if (out_npc !== 32'h44) begin n_err++; $display("FAIL alu_npc: got %h want 44", out_npc); end
        n_cmp++; if ({mem_stall, dmemREN, dmemWEN} !== 3'b000) begin n_err++; $display("FAIL alu_noreq: got %b want 000", {mem_stall, dmemREN, dmemWEN}); end
        @(negedge CLK); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL alu_bubble: got %b want 0", out_valid); end
    endtask

    task automatic test_load();
        int ren_cnt = 0;
        int stall_cnt = 0;
        do_reset();
        ex_valid = 1; ex_aluout = 32'h100; ex_dren = 1; ex_regWrite = 1; ex_memtoReg = 1; ex_wsel = 3;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); clr_in();
            dhit = (k == 3); dmemload = (k == 3) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (dmemREN) ren_cnt++;
            if (mem_stall) stall_cnt++;
            if (k < 3) begin
                n_cmp++; if ({out_valid, out_ldata} !== 33'h0) begin n_err++; $display("FAIL ld_wait: got valid=%b ldata=%h want 0/0", out_valid, out_ldata); end
            end else begin
                n_cmp++; if (out_ldata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_data: got %h want deadbeef", out_ldata); end
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ld_valid: got %b want 1", out_valid); end
                n_cmp++; if (dmemaddr !== 32'h100) begin n_err++; $display("FAIL ld_addr: got %h want 100", dmemaddr); end
            end
        end
        @(negedge CLK); dhit = 0; #1;
        n_cmp++; if (dmemREN !== 1'b0) begin n_err++; $display("FAIL ld_drop: got %b want 0", dmemREN); end
        n_cmp++; if (ren_cnt !== 4) begin n_err++; $display("FAIL ld_ren_cycles: got %0d want 4", ren_cnt); end
        n_cmp++; if (stall_cnt !== 3) begin n_err++; $display("FAIL ld_stall_cycles: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_valid = 1; ex_aluout = 32'h200; ex_wdat = 32'hAAAA0001; ex_dwen = 1;
        @(negedge CLK);
        ex_aluout = 32'h204; ex_wdat = 32'hBBBB0002; dhit = 1; #1;
        n_cmp++; if ({dmemWEN, mem_stall} !== 2'b10) begin n_err++; $display("FAIL b2b_1_req: got %b want 10", {dmemWEN, mem_stall}); end
        n_cmp++; if (dmemaddr !== 32'h200 || dmemstore !== 32'hAAAA0001) begin n_err++; $display("FAIL b2b_1_addr: got %h/%h want 200/aaaa0001", dmemaddr, dmemstore); end
        @(negedge CLK); clr_in(); #1;
        n_cmp++; if ({dmemWEN, mem_stall} !== 2'b10) begin n_err++; $display("FAIL b2b_2_req: got %b want 10", {dmemWEN, mem_stall}); end
        n_cmp++; if (dmemaddr !== 32'h204 || dmemstore !== 32'hBBBB0002) begin n_err++; $display("FAIL b2b_2_addr: got %h/%h want 204/bbbb0002", dmemaddr, dmemstore); end
        @(negedge CLK); dhit = 0; #1;
        n_cmp++; if (dmemWEN !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b want 0", dmemWEN); end
    endtask

    task automatic test_flush();
        do_reset();
        ex_valid = 1; ex_regWrite = 1; ex_aluout = 32'h44; ex_dren = 1; flush = 1;
        @(negedge CLK); clr_in(); #1;
        n_cmp++; if ({out_valid, out_regWrite, dmemREN} !== 3'b000) begin n_err++; $display("FAIL fl_bubble: got %b want 000", {out_valid, out_regWrite, dmemREN}); end
        ex_valid = 1; ex_aluout = 32'h300; ex_dren = 1; ex_regWrite = 1;
        @(negedge CLK); clr_in(); flush = 1; dhit = 0; #1;
        n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL fl_stall: got %b want 1", mem_stall); end
        @(negedge CLK); dhit = 1; #1;
        n_cmp++; if ({out_valid, out_regWrite} !== 2'b11 || out_aluout !== 32'h300) begin n_err++; $display("FAIL fl_survive: got %b/%h want 11/300", {out_valid, out_regWrite}, out_aluout); end
    endtask

    task automatic test_misalign();
        do_reset();
        ex_valid = 1; ex_aluout = 32'h103; ex_dren = 1; ex_regWrite = 1;
        @(negedge CLK); clr_in(); #1;
        n_cmp++; if ({dmemREN, mem_stall} !== 2'b00) begin n_err++; $display("FAIL mis_noreq: got %b want 00", {dmemREN, mem_stall}); end
        n_cmp++; if ({err_misalign, out_regWrite, out_valid} !== 3'b101) begin n_err++; $display("FAIL mis_flags: got %b want 101", {err_misalign, out_regWrite, out_valid}); end
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++; if (err_misalign !== 1'b1) begin n_err++; $display("FAIL mis_sticky: got %b want 1", err_misalign); end
    endtask

    task automatic test_timeout();
        do_reset();
        ex_valid = 1; ex_aluout = 32'h400; ex_dren = 1;
        for (int j = 1; j <= 256; j++) begin
            @(negedge CLK); clr_in(); dhit = 0; #1;
            if (j == 255) begin
                n_cmp++; if ({err_timeout, mem_stall} !== 2'b01) begin n_err++; $display("FAIL to_early: got %b want 01", {err_timeout, mem_stall}); end
            end
            if (j == 256) begin
                n_cmp++; if ({err_timeout, dmemREN} !== 2'b11) begin n_err++; $display("FAIL to_set: got %b want 11", {err_timeout, dmemREN}); end
            end
        end
        @(negedge CLK); dhit = 1; #1;
        n_cmp++; if ({out_valid, err_timeout} !== 2'b11) begin n_err++; $display("FAIL to_finish: got %b want 11", {out_valid, err_timeout}); end
    endtask

    task automatic test_halt();
        do_reset();
        ex_valid = 1; ex_halt = 1; ex_aluout = 32'h55;
        @(negedge CLK); clr_in(); ex_valid = 1; ex_aluout = 32'h77; ex_regWrite = 1; #1;
        n_cmp++; if ({out_halt, out_valid, mem_stall} !== 3'b110) begin n_err++; $display("FAIL halt_first: got %b want 110", {out_halt, out_valid, mem_stall}); end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            n_cmp++; if ({out_halt, out_valid} !== 2'b10 || out_aluout !== 32'h55) begin n_err++; $display("FAIL halt_hold%0d: got %b/%h want 10/55", k, {out_halt, out_valid}, out_aluout); end
            ex_dren = 1; ex_aluout = 32'h600;
        end
        n_cmp++; if ({dmemREN, mem_stall} !== 2'b00) begin n_err++; $display("FAIL halt_noreq: got %b want 00", {dmemREN, mem_stall}); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        ex_valid = 1; ex_aluout = 32'h500; ex_dren = 1; ex_regWrite = 1;
        @(negedge CLK); clr_in(); dhit = 0; #1;
        n_cmp++; if (dmemREN !== 1'b1) begin n_err++; $display("FAIL rma_req: got %b want 1", dmemREN); end
        RST = 1;
        @(negedge CLK); RST = 0; #1;
        n_cmp++; if ({dmemREN, mem_stall, out_valid, out_regWrite} !== 4'b0000) begin n_err++; $display("FAIL rma_ctrl: got %b want 0000", {dmemREN, mem_stall, out_valid, out_regWrite}); end
        n_cmp++; if (out_npc !== RPC || out_aluout !== 32'h0) begin n_err++; $display("FAIL rma_data: got %h/%h want %h/0", out_npc, out_aluout, RPC); end
    endtask

    // Random stream: the head of q is the instruction the stage currently holds.
    task automatic test_random();
        exp_t        q[$];
        exp_t        h, e;
        logic [31:0] r, c_alu, c_wdat, c_npc;
        logic [4:0]  c_wsel;
        logic        c_valid, c_flush, c_dren, c_dwen, c_rw, c_m2r, c_jal;
        logic        has, mem, e_stall, e_valid, e_ren, e_wen, mis, m_misalign;
        logic [31:0] e_ldata;
        int          idx = 0;
        int          cyc = 0;
        int          kind;
        bit          need_new = 1;
        m_misalign = 0;
        c_alu = 0; c_wdat = 0; c_npc = 0; c_wsel = 0;
        c_valid = 0; c_flush = 0; c_dren = 0; c_dwen = 0; c_rw = 0; c_m2r = 0; c_jal = 0;
        do_reset();
        while (idx < 80 && cyc < 2000) begin
            if (cyc > 0) @(negedge CLK);
            cyc++;
            if (need_new) begin
                r = $urandom; kind = $urandom_range(0, 5);
                c_alu = {r[31:2], 2'b00}; c_wdat = $urandom; c_npc = $urandom;
                c_wsel = 5'($urandom_range(0, 31));
                c_valid = ($urandom_range(0, 7) != 0); c_flush = ($urandom_range(0, 5) == 0);
                c_rw = r[0]; c_m2r = r[1]; c_jal = r[2];
                c_dren = (kind == 2) || (kind == 5) || (kind == 4 && r[3]);
                c_dwen = (kind == 3) || (kind == 5) || (kind == 4 && !r[3]);
                if (kind == 4) c_alu[1:0] = 2'($urandom_range(1, 3));
            end
            ex_valid = c_valid; ex_aluout = c_alu; ex_wdat = c_wdat; ex_wsel = c_wsel; ex_npc = c_npc;
            ex_regWrite = c_rw; ex_memtoReg = c_m2r; ex_dren = c_dren; ex_dwen = c_dwen;
            ex_jal = c_jal; ex_halt = 0; flush = c_flush;
            dhit = ($urandom_range(0, 9) < 6); dmemload = $urandom;
            #1;
            has = (q.size() > 0);
            if (has) h = q[0];
            mem     = has && (h.ld || h.st);
            e_stall = mem && !dhit;
            e_valid = has && (!mem || dhit);
            e_ren   = mem && h.ld;
            e_wen   = mem && h.st;
            e_ldata = (e_ren && dhit) ? dmemload : 32'h0;
            n_cmp++; if ({mem_stall, out_valid, dmemREN, dmemWEN} !== {e_stall, e_valid, e_ren, e_wen}) begin n_err++; $display("FAIL rnd_ctrl@%0d: got %b want %b", cyc, {mem_stall, out_valid, dmemREN, dmemWEN}, {e_stall, e_valid, e_ren, e_wen}); end
            n_cmp++; if (out_ldata !== e_ldata) begin n_err++; $display("FAIL rnd_ldata@%0d: got %h want %h", cyc, out_ldata, e_ldata); end
            if (mem) begin
                n_cmp++; if (dmemaddr !== h.alu || (h.st && dmemstore !== h.wdat)) begin n_err++; $display("FAIL rnd_req@%0d: got %h/%h want %h/%h", cyc, dmemaddr, dmemstore, h.alu, h.wdat); end
            end
            if (e_valid) begin
                n_cmp++; if (out_aluout !== h.alu || out_wsel !== h.wsel || out_npc !== h.npc) begin n_err++; $display("FAIL rnd_data@%0d: got %h/%0d/%h want %h/%0d/%h", cyc, out_aluout, out_wsel, out_npc, h.alu, h.wsel, h.npc); end
                n_cmp++; if ({out_regWrite, out_memtoReg, out_jal} !== {h.rw, h.m2r, h.jal}) begin n_err++; $display("FAIL rnd_flags@%0d: got %b want %b", cyc, {out_regWrite, out_memtoReg, out_jal}, {h.rw, h.m2r, h.jal}); end
                void'(q.pop_front());
            end
            need_new = !e_stall;
            if (!e_stall) begin
                idx++;
                if (c_valid && !c_flush) begin
                    mis   = (c_dren || c_dwen) && (c_alu[1:0] != 2'b00);
                    e.alu = c_alu; e.npc = c_npc; e.wdat = c_wdat; e.wsel = c_wsel;
                    e.rw  = c_rw && !mis; e.m2r = c_m2r; e.jal = c_jal;
                    e.ld  = !mis && c_dren; e.st = !mis && c_dwen && !c_dren;
                    if (mis) m_misalign = 1;
                    q.push_back(e);
                end
            end
        end
        n_cmp++; if (idx < 80) begin n_err++; $display("FAIL rnd_budget: got %0d instructions want 80", idx); end
        @(negedge CLK); clr_in(); dhit = 1; #1;
        n_cmp++; if ({err_misalign, err_timeout} !== {m_misalign, 1'b0}) begin n_err++; $display("FAIL rnd_errflags: got %b want %b", {err_misalign, err_timeout}, {m_misalign, 1'b0}); end
    endtask

    initial begin
        RST = 1; clr_in(); dhit = 0; dmemload = 0;
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_flush();
        test_misalign();
        test_timeout();
        test_halt();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller for the 5-stage pipeline.
- Sits directly downstream of the ID/EX register and execute stage; captures ALU results and control signals.
- Drives the data-cache request/handshake and stalls upstream stages until the access completes.
- Presents completed-instruction results to the MEM/WB register.

Parameters:
- TIMEOUT, 255, cycles without dhit before err_timeout asserts (8-bit saturating counter).
- RESET_PC, 32'h0, reset value of out_npc.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- ex_valid  in  1  execute slot holds a real instruction
- ex_aluout  in  32  ALU result / memory address
- ex_wdat  in  32  store data (forwarded rdat2)
- ex_wsel  in  5  destination register
- ex_npc  in  32  PC+4 (for jal writeback)
- ex_regWrite, ex_memtoReg, ex_dren, ex_dwen, ex_jal, ex_halt  in  1 each  control from ID/EX
- flush  in  1  squash the instruction being captured (branch/jump resolved)
- dhit  in  1  data cache access complete
- dmemload  in  32  data cache read data
- dmemREN, dmemWEN  out  1 each  data cache request
- dmemaddr  out  32  request address (= latched aluout)
- dmemstore  out  32  store data
- mem_stall  out  1  hold PC, IF/ID, ID/EX this cycle
- out_valid  out  1  result valid for MEM/WB capture this cycle
- out_aluout, out_npc, out_ldata  out  32 each  results (out_ldata = dmemload on dhit cycle, else 0)
- out_wsel  out  5; out_regWrite, out_memtoReg, out_jal, out_halt  out  1 each
- err_misalign, err_timeout  out  1 each  sticky fault flags

Behaviour:
- Reset (RST=1 at an edge): state IDLE.
  - All registered outputs 0, except out_npc = RESET_PC.
  - dmemREN/WEN = 0; flags cleared; wait counter = 0.
- States:
  - IDLE: slot empty or non-memory instruction.
  - ACCESS: request outstanding.
  - HALTED: terminal state.
- advance = !mem_stall && state != HALTED.
- Capture on advance:
  - If ex_valid && !flush: latch all ex_* fields.
  - Otherwise insert a bubble: valid/regWrite/dren/dwen/halt = 0.
  - flush is sampled only on advance edges; while stalled it is ignored, and upstream must hold it.
- Capture transitions:
  - Captured instruction with dren|dwen and aligned address (aluout[1:0]==0): next state ACCESS.
  - Misaligned: no request issued; err_misalign set (sticky); regWrite suppressed; completes as non-memory instruction in IDLE.
  - Captured halt: HALTED. out_halt=1 and out_valid=1 for exactly one cycle, then out_valid=0 and out_halt held 1 until reset. No further captures; mem_stall=0.
- ACCESS state:
  - dmemREN/WEN = latched dren/dwen (never both; if both set, treat as read).
  - dmemaddr = out_aluout; dmemstore = latched wdat.
  - mem_stall = !dhit; out_valid = dhit.
  - On dhit edge: next state IDLE (or ACCESS if the newly captured instruction is also a memory op). The request drops or re-targets the next cycle.
  - Minimum access latency: 1 cycle (capture at edge T, dhit during cycle T → advance at edge T+1).
- IDLE state: mem_stall = 0; out_valid = latched valid.
- Wait counter: increments each ACCESS cycle without dhit, saturates. Reaching TIMEOUT sets err_timeout (sticky); the access continues waiting.
- Reset mid-ACCESS: requests drop the cycle after the reset edge; the instruction is discarded.
- out_ldata is combinational from dmemload only in the dhit cycle of a read; downstream captures it on that edge.

Test Plan:
- ALU op: ex_valid=1, aluout=32'h10, wsel=5, regWrite=1 → next cycle out_valid=1, out_aluout=32'h10, out_wsel=5, mem_stall=0, no request.
- Load: aluout=32'h100, dren=1; dhit held low 3 cycles, then high with dmemload=32'hDEADBEEF → dmemREN=1 for 4 cycles, mem_stall=1 for 3, out_ldata=32'hDEADBEEF and out_valid=1 in cycle 4, dmemREN=0 the following cycle.
- Back-to-back stores to 32'h200 and 32'h204, dhit immediate → dmemWEN continuous 2 cycles, dmemaddr 32'h200 then 32'h204, zero stall cycles.
- flush=1 with ex_valid=1, regWrite=1 → captured bubble: out_valid=0, out_regWrite=0, no request; flush asserted during a stall → ignored, original instruction still completes.
- Misaligned load aluout=32'h103 → no dmemREN, err_misalign=1 (stays 1), out_regWrite=0.
- Halt then further valid instructions → out_halt=1 persists, no further captures; RST mid-ACCESS with dhit=0 → next cycle dmemREN=0, all outputs at reset values.
